tdc_seq_ctrl: RTL and testbench

Measurement sequencer for the carry-chain TDC delay line.
- Gates the hit signal into the chain's carry input.
- Clears and arms the line, runs a coarse clock counter, and detects the capture cycle from the chain snapshot taken on each clk edge.
- Encodes the thermometer code to a fine count and presents {timeout, coarse, fine} to the readout logic on a valid/ready handshake.

---
 rtl/tdc_seq_ctrl_if.sv | 28 ++
 rtl/tdc_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_tdc_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_seq_ctrl_if.sv
// Readout handshake between the TDC sequencer and the timestamp consumer.
// The sequencer drives the result on the master side; the consumer returns ts_ready.
interface tdc_seq_ctrl_if #(
  parameter int unsigned COARSE_W = 16,
  parameter int unsigned FINE_W   = 6
);
  logic                ts_valid;
  logic                ts_ready;
  logic [COARSE_W-1:0] ts_coarse;
  logic [FINE_W-1:0]   ts_fine;
  logic                ts_timeout;

  modport master (
    output ts_valid,
    output ts_coarse,
    output ts_fine,
    output ts_timeout,
    input  ts_ready
  );

  modport slave (
    input  ts_valid,
    input  ts_coarse,
    input  ts_fine,
    input  ts_timeout,
    output ts_ready
  );
endinterface

// File: rtl/tdc_seq_ctrl.sv
// Measurement sequencer for a carry-chain TDC: gates the hit into the chain,
// counts coarse cycles, encodes the thermometer snapshot and hands off the result.
module tdc_seq_ctrl #(
  parameter int unsigned CHAIN_LEN = 32,
  parameter int unsigned FINE_W    = 6,
  parameter int unsigned COARSE_W  = 16,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned SETTLE    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_arm,
  input  logic [CHAIN_LEN-1:0] i_chain_in,
  output logic                 o_hit_en,
  output logic                 o_busy,
  tdc_seq_ctrl_if.master       o_ts
);

  localparam int unsigned SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_MAX  = SETTLE_W'(SETTLE - 1);
  localparam logic [COARSE_W-1:0] COARSE_LAST = COARSE_W'(TIMEOUT - 1);
  localparam logic [COARSE_W-1:0] COARSE_TO   = COARSE_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARMED,
    S_ENCODE,
    S_DONE
  } state_t;

  state_t               r_state,      w_state;
  logic [SETTLE_W-1:0]  r_settle,     w_settle;
  logic [COARSE_W-1:0]  r_coarse,     w_coarse;
  logic [CHAIN_LEN-1:0] r_snap,       w_snap;
  logic                 r_hit_en,     w_hit_en;
  logic                 r_busy,       w_busy;
  logic                 r_ts_valid,   w_ts_valid;
  logic [COARSE_W-1:0]  r_ts_coarse,  w_ts_coarse;
  logic [FINE_W-1:0]    r_ts_fine,    w_ts_fine;
  logic                 r_ts_timeout, w_ts_timeout;
  logic [FINE_W-1:0]    w_popcnt;
  logic                 w_chain_zero;

  assign w_chain_zero = (i_chain_in == '0);

  // Ones count rather than edge search keeps bubbles from skewing the fine value
  always_comb begin
    w_popcnt = '0;
    for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
      w_popcnt = w_popcnt + FINE_W'(r_snap[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_settle     <= '0;
      r_coarse     <= '0;
      r_snap       <= '0;
      r_hit_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_ts_valid   <= 1'b0;
      r_ts_coarse  <= '0;
      r_ts_fine    <= '0;
      r_ts_timeout <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_settle     <= w_settle;
      r_coarse     <= w_coarse;
      r_snap       <= w_snap;
      r_hit_en     <= w_hit_en;
      r_busy       <= w_busy;
      r_ts_valid   <= w_ts_valid;
      r_ts_coarse  <= w_ts_coarse;
      r_ts_fine    <= w_ts_fine;
      r_ts_timeout <= w_ts_timeout;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_settle     = r_settle;
    w_coarse     = r_coarse;
    w_snap       = r_snap;
    w_ts_coarse  = r_ts_coarse;
    w_ts_fine    = r_ts_fine;
    w_ts_timeout = r_ts_timeout;

    case (r_state)
      S_IDLE: begin
        if (i_arm) begin
          w_state  = S_CLEAR;
          w_settle = '0;
        end
      end

      S_CLEAR: begin
        if ((r_settle == SETTLE_MAX) && w_chain_zero) begin
          w_state  = S_ARMED;
          w_coarse = '0;
        end else if (r_settle != SETTLE_MAX) begin
          w_settle = r_settle + SETTLE_W'(1);
        end
      end

      // On a hit the coarse counter simply stops, holding the capture count
      S_ARMED: begin
        if (!w_chain_zero) begin
          w_state = S_ENCODE;
          w_snap  = i_chain_in;
        end else if (r_coarse == COARSE_LAST) begin
          w_state      = S_DONE;
          w_ts_timeout = 1'b1;
          w_ts_fine    = '0;
          w_ts_coarse  = COARSE_TO;
        end else begin
          w_coarse = r_coarse + COARSE_W'(1);
        end
      end

      S_ENCODE: begin
        w_state      = S_DONE;
        w_ts_timeout = 1'b0;
        w_ts_fine    = w_popcnt;
        w_ts_coarse  = r_coarse;
      end

      S_DONE: begin
        if (o_ts.ts_ready) begin
          w_state = S_IDLE;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_hit_en   = (w_state == S_ARMED);
    w_busy     = (w_state != S_IDLE);
    w_ts_valid = (w_state == S_DONE);
  end

  assign o_hit_en        = r_hit_en;
  assign o_busy          = r_busy;
  assign o_ts.ts_valid   = r_ts_valid;
  assign o_ts.ts_coarse  = r_ts_coarse;
  assign o_ts.ts_fine    = r_ts_fine;
  assign o_ts.ts_timeout = r_ts_timeout;

endmodule

// File: tb/tb_tdc_seq_ctrl.sv
// Directed bench for tdc_seq_ctrl: expected timestamps are queued when the hit
// is driven and compared when the result handshake appears.
module tb_tdc_seq_ctrl;

  localparam int unsigned CHAIN_LEN = 32;
  localparam int unsigned FINE_W    = 6;
  localparam int unsigned COARSE_W  = 16;
  localparam int unsigned TIMEOUT   = 20;
  localparam int unsigned SETTLE    = 4;

  typedef struct {
    int unsigned coarse;
    int unsigned fine;
    bit          tmo;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 arm;
  logic [CHAIN_LEN-1:0] chain;
  logic                 hit_en;
  logic                 busy;

  int   checks;
  int   errors;
  int   hit_cycles;
  exp_t sb[$];
  exp_t last;

  tdc_seq_ctrl_if #(.COARSE_W(COARSE_W), .FINE_W(FINE_W)) u_if ();

  tdc_seq_ctrl #(
    .CHAIN_LEN (CHAIN_LEN),
    .FINE_W    (FINE_W),
    .COARSE_W  (COARSE_W),
    .TIMEOUT   (TIMEOUT),
    .SETTLE    (SETTLE)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_arm      (arm),
    .i_chain_in (chain),
    .o_hit_en   (hit_en),
    .o_busy     (busy),
    .o_ts       (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial hit_cycles = 0;
  always @(negedge clk) if (hit_en === 1'b1) hit_cycles++;

  initial begin
    #200000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, want);
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic wait_hit(input string tag, input int budget, output int n);
    n = 0;
    while (hit_en !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_hit_seen"}, 64'(hit_en), 64'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    while (u_if.ts_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_valid_seen"}, 64'(u_if.ts_valid), 64'd1);
  endtask

  task automatic pop_check(input string tag);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb_empty obs=0 exp=1", tag);
    end
    if (sb.size() > 0) begin
      last = sb.pop_front();
      chk({tag, "_coarse"},  64'(u_if.ts_coarse),  64'(last.coarse));
      chk({tag, "_fine"},    64'(u_if.ts_fine),    64'(last.fine));
      chk({tag, "_timeout"}, 64'(u_if.ts_timeout), 64'(last.tmo));
    end
  endtask

  initial begin
    int n;
    int h0;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    arm = 1'b0;
    chain = '0;
    u_if.ts_ready = 1'b1;

    #1;
    chk("rst_busy",    64'(busy),            64'd0);
    chk("rst_hit_en",  64'(hit_en),          64'd0);
    chk("rst_valid",   64'(u_if.ts_valid),   64'd0);
    chk("rst_coarse",  64'(u_if.ts_coarse),  64'd0);
    chk("rst_fine",    64'(u_if.ts_fine),    64'd0);
    chk("rst_timeout", 64'(u_if.ts_timeout), 64'd0);
    #10 rst = 1'b0;
    step();

    // 1: hit after 10 empty ARMED cycles
    h0 = hit_cycles;
    pulse_arm();
    chk("t1_busy_rise", 64'(busy),   64'd1);
    chk("t1_clear_gate", 64'(hit_en), 64'd0);
    wait_hit("t1", 20, n);
    chk("t1_clear_cycles", 64'(n), 64'(SETTLE));
    repeat (10) step();
    chk("t1_still_armed", 64'(hit_en), 64'd1);
    chain = 32'h0000_00FF;
    sb.push_back('{coarse: 10, fine: 8, tmo: 1'b0});
    step();
    chk("t1_encode_gate",  64'(hit_en),        64'd0);
    chk("t1_encode_valid", 64'(u_if.ts_valid), 64'd0);
    chain = '0;
    step();
    chk("t1_valid_lat", 64'(u_if.ts_valid), 64'd1);
    pop_check("t1");
    chk("t1_busy_done", 64'(busy), 64'd1);
    chk("t1_hit_cycles", 64'(hit_cycles - h0), 64'd11);
    step();
    chk("t1_valid_drop", 64'(u_if.ts_valid), 64'd0);
    chk("t1_busy_fall",  64'(busy),          64'd0);

    // 2: bubble code on the first ARMED cycle
    pulse_arm();
    wait_hit("t2", 20, n);
    chain = 32'h0000_0F7F;
    sb.push_back('{coarse: 0, fine: 11, tmo: 1'b0});
    wait_valid("t2", 10, n);
    chk("t2_latency", 64'(n), 64'd2);
    pop_check("t2");
    chain = '0;
    step();

    // 3: residual chain activity holds the line in CLEAR
    chain = 32'h0000_0003;
    pulse_arm();
    for (int i = 0; i < 5; i++) begin
      chk("t3_clear_hold", 64'(hit_en), 64'd0);
      step();
    end
    chk("t3_clear_hold_last", 64'(hit_en), 64'd0);
    chain = '0;
    step();
    chk("t3_armed_now", 64'(hit_en), 64'd1);
    repeat (2) step();
    chain = 32'h0000_0007;
    sb.push_back('{coarse: 2, fine: 3, tmo: 1'b0});
    wait_valid("t3", 10, n);
    chk("t3_latency", 64'(n), 64'd2);
    pop_check("t3");
    chain = '0;
    step();

    // 4a: no hit at all
    h0 = hit_cycles;
    pulse_arm();
    wait_hit("t4a", 20, n);
    sb.push_back('{coarse: TIMEOUT, fine: 0, tmo: 1'b1});
    wait_valid("t4a", 60, n);
    chk("t4a_armed_cycles", 64'(n), 64'(TIMEOUT));
    chk("t4a_hit_cycles", 64'(hit_cycles - h0), 64'(TIMEOUT));
    pop_check("t4a");
    step();

    // 4b: full-scale hit on the last ARMED cycle beats the timeout
    pulse_arm();
    wait_hit("t4b", 20, n);
    repeat (TIMEOUT - 1) step();
    chain = 32'hFFFF_FFFF;
    sb.push_back('{coarse: TIMEOUT - 1, fine: CHAIN_LEN, tmo: 1'b0});
    wait_valid("t4b", 10, n);
    chk("t4b_latency", 64'(n), 64'd2);
    pop_check("t4b");
    chain = '0;
    step();

    // 5: back-pressure in DONE with stray arm and chain activity
    u_if.ts_ready = 1'b0;
    pulse_arm();
    wait_hit("t5", 20, n);
    repeat (2) step();
    chain = 32'h0000_003F;
    sb.push_back('{coarse: 2, fine: 6, tmo: 1'b0});
    wait_valid("t5", 10, n);
    pop_check("t5");
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid",   64'(u_if.ts_valid),   64'd1);
      chk("t5_hold_coarse",  64'(u_if.ts_coarse),  64'(last.coarse));
      chk("t5_hold_fine",    64'(u_if.ts_fine),    64'(last.fine));
      chk("t5_hold_timeout", 64'(u_if.ts_timeout), 64'(last.tmo));
      chk("t5_hold_gate",    64'(hit_en),          64'd0);
      arm = 1'b1;
      chain = CHAIN_LEN'($urandom);
      step();
      arm = 1'b0;
    end
    chk("t5_valid_6th", 64'(u_if.ts_valid), 64'd1);
    u_if.ts_ready = 1'b1;
    chain = '0;
    step();
    chk("t5_valid_drop", 64'(u_if.ts_valid),  64'd0);
    chk("t5_busy_fall",  64'(busy),           64'd0);
    chk("t5_keep_fine",  64'(u_if.ts_fine),   64'(last.fine));
    repeat (3) step();
    chk("t5_no_queued_arm", 64'(busy), 64'd0);

    // 6: asynchronous reset in the middle of ARMED
    pulse_arm();
    wait_hit("t6", 20, n);
    repeat (3) step();
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_hit_en", 64'(hit_en),          64'd0);
    chk("t6_rst_busy",   64'(busy),            64'd0);
    chk("t6_rst_valid",  64'(u_if.ts_valid),   64'd0);
    chk("t6_rst_coarse", 64'(u_if.ts_coarse),  64'd0);
    #1 rst = 1'b0;
    step();
    chk("t6_idle_after", 64'(busy), 64'd0);
    pulse_arm();
    wait_hit("t6b", 20, n);
    chk("t6b_clear_cycles", 64'(n), 64'(SETTLE));
    repeat (5) step();
    chain = 32'h0001_FFFF;
    sb.push_back('{coarse: 5, fine: 17, tmo: 1'b0});
    wait_valid("t6b", 10, n);
    chk("t6b_latency", 64'(n), 64'd2);
    pop_check("t6b");
    chain = '0;
    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
